// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/JUMP/HALT sequencer driven by decoded control signals.
// Optional performance counters (cycle_count, instret_count) are built when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer
`ifdef SEQ_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ins_type,
    input  logic [1:0] pc_src,
    input  logic       reg_w,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       jal,
    input  logic       stop,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       alu_out_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic       link_write,
    output logic       instr_done,
    output logic       halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        JUMP   = 3'd5,
        HALT   = 3'd6
    } state_e;

    state_e state_q, state_d;
    logic   stopPending_q, stopPending_d;
    state_e doneState;

    logic irWrite, pcWrite, memReq, memWe, iordSel, aluOutWrite;
    logic mdrWrite, regWrite, linkWrite, instrDone, haltedInt;

    // Next-state and strobe decode; the instruction's last cycle retires to FETCH, or HALT when a stop is pending.
    always_comb begin
        state_d       = state_q;
        stopPending_d = stopPending_q;
        irWrite       = 1'b0;
        pcWrite       = 1'b0;
        memReq        = 1'b0;
        memWe         = 1'b0;
        iordSel       = 1'b0;
        aluOutWrite   = 1'b0;
        mdrWrite      = 1'b0;
        regWrite      = 1'b0;
        linkWrite     = 1'b0;
        instrDone     = 1'b0;
        haltedInt     = 1'b0;
        doneState     = stopPending_q ? HALT : FETCH;

        case (state_q)
            FETCH: begin
                memReq = 1'b1;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                stopPending_d = stop | (pc_src == 2'b11);
                state_d       = (ins_type == 2'b10) ? JUMP : EXEC;
            end
            JUMP: begin
                pcWrite   = ~stopPending_q;
                linkWrite = jal;
                instrDone = 1'b1;
                state_d   = doneState;
            end
            EXEC: begin
                aluOutWrite = 1'b1;
                if (ins_type == 2'b01 && pc_src == 2'b01) begin
                    pcWrite   = zero & ~stopPending_q;
                    instrDone = 1'b1;
                    state_d   = doneState;
                end else if (mem_read || mem_write) begin
                    state_d = MEM;
                end else if (reg_w) begin
                    state_d = WB;
                end else begin
                    instrDone = 1'b1;
                    state_d   = doneState;
                end
            end
            MEM: begin
                memReq  = 1'b1;
                iordSel = 1'b1;
                memWe   = mem_write;
                if (mem_ready) begin
                    if (mem_read) begin
                        mdrWrite = 1'b1;
                        state_d  = WB;
                    end else begin
                        instrDone = 1'b1;
                        state_d   = doneState;
                    end
                end
            end
            WB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                state_d   = doneState;
            end
            HALT: begin
                haltedInt = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and pending-stop registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            stopPending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stopPending_q <= stopPending_d;
        end
    end

    // Every output is held low while reset is asserted so an abandoned instruction emits no strobes.
    assign state         = reset ? 3'd0 : state_q;
    assign ir_write      = ~reset & irWrite;
    assign pc_write      = ~reset & pcWrite;
    assign mem_req       = ~reset & memReq;
    assign mem_we        = ~reset & memWe;
    assign iord          = ~reset & iordSel;
    assign alu_out_write = ~reset & aluOutWrite;
    assign mdr_write     = ~reset & mdrWrite;
    assign reg_write     = ~reset & regWrite;
    assign link_write    = ~reset & linkWrite;
    assign instr_done    = ~reset & instrDone;
    assign halted        = ~reset & haltedInt;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycleCount_q, instretCount_q;

    // Free-running counters that wrap naturally; HALT cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount_q   <= '0;
            instretCount_q <= '0;
        end else begin
            if (state_q != HALT) begin
                cycleCount_q <= cycleCount_q + CNT_W'(1);
            end
            if (instrDone) begin
                instretCount_q <= instretCount_q + CNT_W'(1);
            end
        end
    end

    assign cycle_count   = reset ? '0 : cycleCount_q;
    assign instret_count = reset ? '0 : instretCount_q;
`endif

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle state sequencer that sits directly downstream of the combinational control unit.
- Consumes the decoded control signals (instruction type, PC source, register/memory write intent, jal, stop) plus the ALU zero flag and memory ready.
- Produces per-cycle strobes for the IR, PC, memory port, ALU output register, MDR and register file.
- One instruction completes every 3-5 cycles; memory wait states are absorbed by a request/ready handshake.

Parameters:
- CNT_W, 32, width of the performance counters (only used with PERF_CNT_EN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ins_type  in  2  instruction type from control unit: 00 R, 01 I, 10 J, 11 shift/other.
- pc_src  in  2  control-unit PC source: 00 seq, 01 branch, 10 jump, 11 stop.
- reg_w  in  1  instruction writes register file.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- jal  in  1  jump-and-link.
- stop  in  1  instruction's stop bit (control unit stopOUT).
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- state  out  3  current state encoding.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC (datapath selects value by pc_src).
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- alu_out_write  out  1  latch ALU result.
- mdr_write  out  1  latch memory read data.
- reg_write  out  1  register-file write strobe.
- link_write  out  1  write return address to link register.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- halted  out  1  sequencer in HALT.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, JUMP=5, HALT=6.
- reset (sampled high on clk edge): state<=FETCH, stop_pending<=0.
- While reset is high, all outputs are forced 0 (state output reads 0). Reset mid-instruction abandons it with no strobes.
- Outputs are combinational from state and inputs. No other registers except stop_pending and the optional counters.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+1), then go to DECODE.
  - Otherwise stay in FETCH with all strobes except mem_req at 0.
- DECODE:
  - Control inputs are valid from this state onward (IR now loaded).
  - stop_pending <= stop | (pc_src==11).
  - ins_type==10 goes to JUMP; all other types go to EXEC.
- JUMP:
  - pc_write=1 only if stop_pending=0; link_write=jal; instr_done=1.
  - Next state: HALT if stop_pending, else FETCH.
- EXEC: alu_out_write=1.
  - Branch (ins_type 01, pc_src 01): pc_write=zero & ~stop_pending; instr_done=1; go to FETCH, or HALT if stop_pending.
  - Load or store: go to MEM.
  - Otherwise, reg_w=1: go to WB.
  - Otherwise (reg_w=0, no memory): instr_done=1; go to FETCH or HALT.
- MEM:
  - mem_req=1, iord=1, mem_we=mem_write.
  - Wait in MEM until mem_ready.
  - On ready with a load: mdr_write=1, go to WB.
  - On ready with a store: instr_done=1, go to FETCH or HALT.
- WB: reg_write=1, instr_done=1; go to FETCH or HALT per stop_pending.
- HALT: all strobes 0, halted=1; stays until reset.
- Control inputs must be held stable by the IR from DECODE to the end of the instruction. The sequencer does not re-register them.
- mem_ready outside FETCH/MEM is ignored.
- mem_ready asserted on the same edge as reset is ignored.
- Latencies (zero wait states):
  - R / ALU-imm: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Jump: 3 cycles.
  - Each wait cycle adds 1.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_count and instret_count, both CNT_W wide.
  - Both clear on reset.
  - cycle_count increments every non-HALT cycle.
  - instret_count increments on each instr_done.
  - Both wrap to 0 from all-ones.
- When undefined: the ports and the logic are absent.

Test Plan:
- R-type (ins_type=00, reg_w=1), mem_ready tied 1 -> states 0,1,2,4,0; reg_write and instr_done high only in cycle 4.
- Load (ins_type=01, mem_read=1, reg_w=1), mem_ready low 2 cycles in MEM -> MEM held 3 cycles, mem_req=1 and iord=1 throughout; mdr_write on ready cycle; total 7 cycles.
- Branch (pc_src=01): zero=1 -> pc_write=1 in EXEC. Repeat with zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- jal (ins_type=10, jal=1) -> JUMP with pc_write=1 and link_write=1, then FETCH; with jal=0, link_write stays 0.
- Store with stop=1 -> mem_we=1 in MEM, then HALT; halted=1 indefinitely with mem_ready toggling; reset returns to FETCH.
- Assert reset during MEM of a store -> no mem_req on the reset cycle, state=0 next cycle; with SEQ_PERF_CNT_EN, both counters read 0.
